// File: rtl/regs_mp.sv
// rtl/regs_mp.sv - multi-port register file with write bypass, pending scoreboard and reset sweep
//
// Purpose: XLEN x NREG register file with NRD combinational read ports,
// two write ports (B wins on address collision), a per-register pending
// scoreboard and a sequential zeroing sweep after reset.
//
// Ports:
//   clk         in   sole clock, rising edge
//   rst         in   synchronous active-high reset, restarts the sweep
//   rd_addr     in   NRD*AW, port i at [i*AW +: AW]
//   rd_data     out  NRD*XLEN, port i at [i*XLEN +: XLEN], combinational
//   rd_pend     out  NRD, pending flag per read port
//   wa_*/wb_*   in   write ports A and B (en, addr, data)
//   alloc_en    in   mark alloc_addr pending
//   alloc_addr  in   AW
//   ready       out  high once the sweep has finished (RUN state)

module regs_mp #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_pend,
  input  logic                wa_en,
  input  logic [AW-1:0]       wa_addr,
  input  logic [XLEN-1:0]     wa_data,
  input  logic                wb_en,
  input  logic [AW-1:0]       wb_addr,
  input  logic [XLEN-1:0]     wb_data,
  input  logic                alloc_en,
  input  logic [AW-1:0]       alloc_addr,
  output logic                ready
);

  typedef enum logic {S_CLEAR = 1'b0, S_RUN = 1'b1} state_t;

  state_t          r_state;
  logic [AW-1:0]   r_cnt;
  logic            r_ready;
  logic [XLEN-1:0] r_regs [NREG];
  logic [NREG-1:0] r_pend;

  logic            w_run;
  logic            w_wa_ok;
  logic            w_wb_ok;
  logic            w_alloc_ok;
  logic [AW-1:0]   w_ra   [NRD];
  logic [XLEN-1:0] w_rd   [NRD];
  logic            w_pend [NRD];
  logic            w_byp  [NRD];

  assign w_run = (r_state == S_RUN);

  // A write or alloc is effective only in RUN and never to the hardwired zero register.
  assign w_wa_ok    = w_run && wa_en    && !((ZERO_REG != 0) && (wa_addr    == '0));
  assign w_wb_ok    = w_run && wb_en    && !((ZERO_REG != 0) && (wb_addr    == '0));
  assign w_alloc_ok = w_run && alloc_en && !((ZERO_REG != 0) && (alloc_addr == '0));

  assign ready = r_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_CLEAR;
      r_cnt   <= '0;
      r_ready <= 1'b0;
    end else begin
      case (r_state)
        S_CLEAR: begin
          r_regs[r_cnt] <= '0;
          r_pend[r_cnt] <= 1'b0;
          r_cnt         <= r_cnt + 1'b1;
          if (r_cnt == AW'(NREG - 1)) begin
            r_state <= S_RUN;
            r_ready <= 1'b1;
          end
        end
        default: begin
          // Later assignments win: B over A for data, alloc over write for pending.
          if (w_wa_ok) begin
            r_regs[wa_addr] <= wa_data;
            r_pend[wa_addr] <= 1'b0;
          end
          if (w_wb_ok) begin
            r_regs[wb_addr] <= wb_data;
            r_pend[wb_addr] <= 1'b0;
          end
          if (w_alloc_ok) begin
            r_pend[alloc_addr] <= 1'b1;
          end
        end
      endcase
    end
  end

  always_comb begin
    rd_data = '0;
    rd_pend = '0;
    for (int i = 0; i < NRD; i++) begin
      w_ra[i]   = rd_addr[i*AW +: AW];
      w_rd[i]   = r_regs[w_ra[i]];
      w_pend[i] = r_pend[w_ra[i]];
      w_byp[i]  = 1'b0;
      if (w_wa_ok && (wa_addr == w_ra[i])) begin
        w_rd[i]  = wa_data;
        w_byp[i] = 1'b1;
      end
      if (w_wb_ok && (wb_addr == w_ra[i])) begin
        w_rd[i]  = wb_data;
        w_byp[i] = 1'b1;
      end
      // Stored contents are not meaningful until the sweep completes.
      if (!w_run || ((ZERO_REG != 0) && (w_ra[i] == '0))) begin
        w_rd[i]   = '0;
        w_pend[i] = 1'b0;
      end
      rd_data[i*XLEN +: XLEN] = w_rd[i];
      rd_pend[i]              = w_pend[i] && !w_byp[i];
    end
  end

endmodule
